sdram_req_master: RTL and testbench
===================================

Name: sdram_req_master

Overview:
Initiator side of the SDRAM controller request/ack interface. It accepts one host read or write burst at a time and raises sdram_wr_req or sdram_rd_req. It supplies write bytes on sdwr_bytes and captures read bytes from sdrd_bytes, then reports completion or a timeout to the host. It sits between the CPU/memory-mapped bus glue and sdram_ctrl.

Parameters:
BURST_LEN, 8, bytes per burst (power of two, 2..16)
TIMEOUT, 1023, max cycles from request assertion to first controller response before abort
CW, 10, width of timeout counter (must hold TIMEOUT)

Ports:
clk_100m  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
sdram_init_done  in  1  controller initialisation complete
sdram_wr_req  out  1  write request to controller
sdram_rd_req  out  1  read request to controller
sdram_wr_ack  in  1  controller write-complete ack (level, >=1 cycle)
sdram_rd_ack  in  1  controller read-data strobe; one byte valid per high cycle
sd_wr_data_en  in  1  controller consumes one write byte per high cycle
sdwr_bytes  out  8  write byte to controller
sdrd_bytes  in  8  read byte from controller
wbuf_push  in  1  host loads one write byte
wbuf_data  in  8  byte for wbuf_push
wbuf_full  out  1  BURST_LEN bytes loaded
cmd_valid  in  1  host command strobe
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
rd_data  out  8  read byte to host
rd_valid  out  1  rd_data valid (one cycle per byte)
done  out  1  one-cycle pulse: burst completed
err  out  1  one-cycle pulse: burst aborted by timeout
busy  out  1  state != S_IDLE

Behaviour:
- Reset (rst high at clk edge): state S_INIT; all outputs 0; sdwr_bytes 0; wbuf count 0, index 0; timeout counter 0. Reset mid-burst drops any request immediately on the next edge and discards buffered bytes.
- Write buffer: BURST_LEN x 8 register array. wbuf_push writes at count and increments it. Pushes are ignored when full or when not in S_IDLE. wbuf_full = (count == BURST_LEN).
- cmd_ready = (state==S_IDLE) & (cmd_wr ? wbuf_full : 1).
- FSM states:
  - S_INIT: wait for sdram_init_done, then go to S_IDLE.
  - S_IDLE: on accepted command, go to S_WREQ (write) or S_RREQ (read). Clear the timeout counter.
  - S_WREQ: sdram_wr_req=1. On first sd_wr_data_en, go to S_WDATA. If sdram_wr_ack arrives without any data phase, go to S_ERR.
  - S_WDATA: sdram_wr_req=1 until the first data cycle. sdwr_bytes = wbuf[idx], driven combinationally from idx. idx advances on each sd_wr_data_en. When BURST_LEN bytes are consumed, go to S_WACK.
  - S_WACK: wait for sdram_wr_ack, then pulse done, clear count and idx, go to S_IDLE.
  - S_RREQ: sdram_rd_req=1. On first sdram_rd_ack, capture the byte, set idx=1, drop the request, go to S_RDATA.
  - S_RDATA: each sdram_rd_ack cycle gives rd_data<=sdrd_bytes and rd_valid=1, registered one cycle after the ack. After BURST_LEN bytes, pulse done and go to S_IDLE.
  - S_ERR: pulse err, drop requests, clear buffer, go to S_IDLE.
- Read latency: rd_valid is exactly 1 cycle after each sdram_rd_ack. done coincides with the last rd_valid.
- Write latency: done is 1 cycle after sdram_wr_ack is seen in S_WACK.
- Timeout: the counter runs in S_WREQ, S_RREQ and S_WACK, and saturates at TIMEOUT. Reaching TIMEOUT goes to S_ERR. The counter is cleared on each state change.
- If sdram_init_done falls outside S_INIT, finish the current state's transition, then go to S_INIT instead of S_IDLE. Outstanding requests are dropped.
- sdram_wr_req and sdram_rd_req are never high together.
- Extra acks or data strobes arriving after the count completes are ignored.
- cmd_valid while busy is ignored; it is not queued.

Decomposition:
- Shared package holds state encodings S_INIT..S_ERR, and defaults for BURST_LEN and TIMEOUT, alongside the controller's `W_*` / `I_*` definitions.
- One sub-module, sdram_wbuf: BURST_LEN x 8 write buffer with push, count, full and indexed read port.

Test Plan:
- Init gating: hold sdram_init_done=0 for 100 cycles with cmd_valid=1 -> cmd_ready=0 and no requests. Raise init_done -> cmd_ready=1 next cycle.
- Write burst: push 0x10..0x17, cmd_wr=1. Controller model asserts sd_wr_data_en for 8 cycles, then wr_ack -> sdwr_bytes sequence 0x10..0x17, then one done pulse; wbuf_full=0 afterwards.
- Read burst: cmd_wr=0. Model gives rd_ack for 8 cycles with 0xA0..0xA7 -> rd_valid 8 cycles, each 1 cycle after its ack, same data. done on the 8th beat; sdram_rd_req low after the first ack.
- Timeout: read command, model never acks -> sdram_rd_req high for 1023 cycles, then err pulse, req low, busy=0.
- Reset mid-write after 3 data bytes -> next cycle all outputs 0, state S_INIT, wbuf empty, no done or err.
- Write with cmd_valid while wbuf holds 7 bytes -> not accepted. 8th push, then cmd_valid -> accepted.

Source files
------------

// File: rtl/sdram_req_master_pkg.sv
// rtl/sdram_req_master_pkg.sv - shared states and defaults for the SDRAM request master
package sdram_req_master_pkg;

    localparam int BURST_LEN_DEF = 8;
    localparam int TIMEOUT_DEF   = 1023;
    localparam int CW_DEF        = 10;

    // Request master states
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WREQ,
        S_WDATA,
        S_WACK,
        S_RREQ,
        S_RDATA,
        S_ERR
    } state_t;

    // Controller-side work-state codes (sdram_ctrl)
    localparam logic [3:0] W_IDLE   = 4'd0;
    localparam logic [3:0] W_ACTIVE = 4'd1;
    localparam logic [3:0] W_TRCD   = 4'd2;
    localparam logic [3:0] W_READ   = 4'd3;
    localparam logic [3:0] W_WRITE  = 4'd4;
    localparam logic [3:0] W_PRE    = 4'd5;

    // Controller-side init-state codes (sdram_ctrl)
    localparam logic [3:0] I_NOP    = 4'd0;
    localparam logic [3:0] I_PRE    = 4'd1;
    localparam logic [3:0] I_AR     = 4'd2;
    localparam logic [3:0] I_MRS    = 4'd3;
    localparam logic [3:0] I_DONE   = 4'd4;

endpackage

// File: rtl/sdram_req_master_wbuf.sv
// rtl/sdram_req_master_wbuf.sv - BURST_LEN x 8 write buffer with push, full and indexed read
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_push_en         : pushes are accepted only while high
//   i_push/i_push_data: load one byte at the current count
//   i_clear           : drop all buffered bytes
//   i_rd_idx/o_rd_data: combinational indexed read
//   o_full            : BURST_LEN bytes loaded
module sdram_wbuf #(
    parameter int BURST_LEN = 8,
    parameter int IW        = $clog2(BURST_LEN) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push_en,
    input  logic          i_push,
    input  logic [7:0]    i_push_data,
    input  logic          i_clear,
    input  logic [IW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_data,
    output logic          o_full
);

    logic [7:0]    r_mem [BURST_LEN];
    logic [IW-1:0] r_count;

    assign o_full    = (r_count == IW'(BURST_LEN));
    // The index wraps to slot 0 once it reaches BURST_LEN; the top gates the byte then.
    assign o_rd_data = r_mem[i_rd_idx[IW-2:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_push && i_push_en && !o_full) begin
            r_mem[r_count[IW-2:0]] <= i_push_data;
            r_count                <= r_count + IW'(1);
        end
    end

endmodule

// File: rtl/sdram_req_master.sv
// rtl/sdram_req_master.sv - host-side initiator of the SDRAM controller request/ack interface
//   clk_100m, rst            : clock, synchronous active-high reset
//   sdram_init_done          : controller ready; gates leaving S_INIT
//   sdram_wr_req/rd_req      : requests to the controller (never both high)
//   sdram_wr_ack/rd_ack      : write done level / read byte strobe
//   sd_wr_data_en/sdwr_bytes : controller write-byte consume strobe and byte
//   sdrd_bytes               : read byte from controller
//   wbuf_push/data/full      : host write-buffer load
//   cmd_valid/wr/ready       : host command handshake
//   rd_data/rd_valid         : read bytes to host, one cycle after each ack
//   done/err/busy            : completion pulse, timeout pulse, burst in flight
module sdram_req_master
    import sdram_req_master_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic       clk_100m,
    input  logic       rst,
    input  logic       sdram_init_done,
    output logic       sdram_wr_req,
    output logic       sdram_rd_req,
    input  logic       sdram_wr_ack,
    input  logic       sdram_rd_ack,
    input  logic       sd_wr_data_en,
    output logic [7:0] sdwr_bytes,
    input  logic [7:0] sdrd_bytes,
    input  logic       wbuf_push,
    input  logic [7:0] wbuf_data,
    output logic       wbuf_full,
    input  logic       cmd_valid,
    input  logic       cmd_wr,
    output logic       cmd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int            IW      = $clog2(BURST_LEN) + 1;
    localparam logic [IW-1:0] IDX_LST = IW'(BURST_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LST = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_wr_req;
    logic          r_rd_req;
    logic          r_done;
    logic          r_err;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;

    logic          w_push_en;
    logic          w_clear;
    logic [7:0]    w_wbuf_byte;
    logic          w_timeout;
    logic [CW-1:0] w_cnt_inc;
    state_t        w_home;

    // Where a finished burst returns: losing init_done sends us back to S_INIT.
    assign w_home    = sdram_init_done ? S_IDLE : S_INIT;
    assign cmd_ready = (r_state == S_IDLE) && sdram_init_done && (cmd_wr ? wbuf_full : 1'b1);
    assign w_push_en = (r_state == S_IDLE);
    assign w_clear   = (r_state == S_ERR) || ((r_state == S_WACK) && sdram_wr_ack);
    // Abort on the cycle the counter would reach TIMEOUT, so a request lasts TIMEOUT cycles.
    assign w_timeout = (r_cnt == CNT_LST);
    assign w_cnt_inc = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);

    assign sdwr_bytes   = ((r_state == S_WREQ) || (r_state == S_WDATA)) ? w_wbuf_byte : 8'h00;
    assign sdram_wr_req = r_wr_req;
    assign sdram_rd_req = r_rd_req;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign done         = r_done;
    assign err          = r_err;
    // S_INIT is not a burst, so busy stays low there as well as in S_IDLE.
    assign busy         = (r_state != S_IDLE) && (r_state != S_INIT);

    sdram_wbuf #(
        .BURST_LEN (BURST_LEN),
        .IW        (IW)
    ) u_wbuf (
        .i_clk       (clk_100m),
        .i_rst       (rst),
        .i_push_en   (w_push_en),
        .i_push      (wbuf_push),
        .i_push_data (wbuf_data),
        .i_clear     (w_clear),
        .i_rd_idx    (r_idx),
        .o_rd_data   (w_wbuf_byte),
        .o_full      (wbuf_full)
    );

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_cnt      <= '0;
            case (r_state)
                S_INIT: begin
                    if (sdram_init_done) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    r_idx <= '0;
                    if (!sdram_init_done) begin
                        r_state <= S_INIT;
                    end else if (cmd_valid && cmd_ready) begin
                        if (cmd_wr) begin
                            r_state  <= S_WREQ;
                            r_wr_req <= 1'b1;
                        end else begin
                            r_state  <= S_RREQ;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                S_WREQ: begin
                    // The first strobe already consumes byte 0.
                    if (sd_wr_data_en) begin
                        r_wr_req <= 1'b0;
                        r_idx    <= r_idx + IW'(1);
                        r_state  <= S_WDATA;
                    end else if (sdram_wr_ack || w_timeout) begin
                        r_wr_req <= 1'b0;
                        r_state  <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WDATA: begin
                    if (sd_wr_data_en) begin
                        r_idx <= r_idx + IW'(1);
                        if (r_idx == IDX_LST) r_state <= S_WACK;
                    end
                end
                S_WACK: begin
                    if (sdram_wr_ack) begin
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= w_home;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RREQ: begin
                    if (sdram_rd_ack) begin
                        r_rd_data  <= sdrd_bytes;
                        r_rd_valid <= 1'b1;
                        r_idx      <= IW'(1);
                        r_rd_req   <= 1'b0;
                        r_state    <= S_RDATA;
                    end else if (w_timeout) begin
                        r_rd_req <= 1'b0;
                        r_state  <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RDATA: begin
                    if (sdram_rd_ack) begin
                        r_rd_data  <= sdrd_bytes;
                        r_rd_valid <= 1'b1;
                        r_idx      <= r_idx + IW'(1);
                        if (r_idx == IDX_LST) begin
                            r_done  <= 1'b1;
                            r_state <= w_home;
                        end
                    end
                end
                S_ERR: begin
                    r_err    <= 1'b1;
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b0;
                    r_idx    <= '0;
                    r_state  <= w_home;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_master.sv
// tb/tb_sdram_req_master.sv - randomized self-checking bench for sdram_req_master
module tb_sdram_req_master;

    localparam int BL = 8;
    localparam int TO = 1023;

    logic       clk_100m = 1'b0;
    logic       rst;
    logic       sdram_init_done;
    logic       sdram_wr_req;
    logic       sdram_rd_req;
    logic       sdram_wr_ack;
    logic       sdram_rd_ack;
    logic       sd_wr_data_en;
    logic [7:0] sdwr_bytes;
    logic [7:0] sdrd_bytes;
    logic       wbuf_push;
    logic [7:0] wbuf_data;
    logic       wbuf_full;
    logic       cmd_valid;
    logic       cmd_wr;
    logic       cmd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int both_hi  = 0;
    int stray    = 0;

    // Reference write buffer: bytes the host has loaded that a write burst must emit.
    logic [7:0] wq[$];

    always #5 clk_100m = ~clk_100m;

    always @(negedge clk_100m) if (sdram_wr_req && sdram_rd_req) both_hi++;

    sdram_req_master u_dut (
        .clk_100m        (clk_100m),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sd_wr_data_en   (sd_wr_data_en),
        .sdwr_bytes      (sdwr_bytes),
        .sdrd_bytes      (sdrd_bytes),
        .wbuf_push       (wbuf_push),
        .wbuf_data       (wbuf_data),
        .wbuf_full       (wbuf_full),
        .cmd_valid       (cmd_valid),
        .cmd_wr          (cmd_wr),
        .cmd_ready       (cmd_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .done            (done),
        .err             (err),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk_100m);
    endtask

    // Host loads bytes while idle; the model keeps only the first BL of them.
    task automatic push_bytes(input int n, input bit fixed, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            nedge();
            wbuf_push = 1'b1;
            wbuf_data = fixed ? base + 8'(i) : 8'($urandom);
            if (wq.size() < BL) wq.push_back(wbuf_data);
        end
        nedge();
        wbuf_push = 1'b0;
    endtask

    task automatic run_write(input int pre_wait, input int ack_wait);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int n = 0, guard = 0, req_late = 0, spurious = 0;
        exp_q = wq;
        nedge();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        #1 check("wr_cmd_ready", cmd_ready, 1);
        nedge();
        cmd_valid = 1'b0;
        check("wr_req_up", sdram_wr_req, 1);
        check("wr_busy", busy, 1);
        repeat (pre_wait) begin
            nedge();
            if (!sdram_wr_req) req_late++;
        end
        while (n < BL && guard < 64) begin
            guard++;
            sd_wr_data_en = (n == 0) || ($urandom_range(3) != 0);
            #1;
            if (sd_wr_data_en) begin
                got_q.push_back(sdwr_bytes);
                n++;
            end
            nedge();
            if (n > 0 && sdram_wr_req) req_late++;
            if (done || err) spurious++;
        end
        sd_wr_data_en = 1'b0;
        check("wr_beats", n, BL);
        repeat (ack_wait) begin
            nedge();
            if (done || err) spurious++;
        end
        sdram_wr_ack = 1'b1;
        nedge();
        sdram_wr_ack = 1'b0;
        check("wr_req_timing", req_late, 0);
        check("wr_early_pulse", spurious, 0);
        check("wr_done", done, 1);
        check("wr_no_err", err, 0);
        nedge();
        check("wr_done_one_cycle", done, 0);
        check("wr_idle", busy, 0);
        check("wr_buf_empty", wbuf_full, 0);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("wr_byte%0d", i), got_q[i], exp_q[i]);
        wq.delete();
    endtask

    task automatic run_read(input int pre_wait, input bit fixed);
        int n = 0, seen = 0, guard = 0, bad_req = 0;
        bit prev_ack = 1'b0, prev_last = 1'b0, ack;
        logic [7:0] prev_b = 8'h00;
        nedge();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        #1 check("rd_cmd_ready", cmd_ready, 1);
        nedge();
        cmd_valid = 1'b0;
        check("rd_req_up", sdram_rd_req, 1);
        check("rd_no_wr_req", sdram_wr_req, 0);
        repeat (pre_wait) begin
            nedge();
            if (!sdram_rd_req) bad_req++;
        end
        check("rd_req_held", bad_req, 0);
        while ((n < BL || prev_ack) && guard < 64) begin
            guard++;
            if (prev_ack) begin
                seen++;
                check("rd_valid", rd_valid, 1);
                check("rd_data", rd_data, prev_b);
                check("rd_done", done, prev_last);
                if (seen == 1) check("rd_req_drop", sdram_rd_req, 0);
            end else if (rd_valid || done) begin
                stray++;
            end
            ack = (n < BL) && (fixed || n == 0 || $urandom_range(2) != 0);
            sdram_rd_ack = ack;
            if (ack) begin
                prev_b     = fixed ? 8'hA0 + 8'(n) : 8'($urandom);
                sdrd_bytes = prev_b;
                n++;
                prev_last  = (n == BL);
            end
            prev_ack = ack;
            nedge();
        end
        check("rd_beats", seen, BL);
        // An extra strobe after the burst must be ignored.
        sdram_rd_ack = 1'b1;
        sdrd_bytes   = 8'h5A;
        nedge();
        sdram_rd_ack = 1'b0;
        check("rd_extra_ignored", rd_valid, 0);
        check("rd_idle", busy, 0);
        check("rd_req_low", sdram_rd_req, 0);
    endtask

    initial begin
        int bad, hi;
        rst = 1'b1; sdram_init_done = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        sd_wr_data_en = 1'b0; sdrd_bytes = 8'h00; wbuf_push = 1'b0; wbuf_data = 8'h00;
        cmd_valid = 1'b0; cmd_wr = 1'b0;
        repeat (3) nedge();
        check("rst_outputs", {sdram_wr_req, sdram_rd_req, wbuf_full, cmd_ready,
                              rd_valid, done, err, busy}, 0);
        check("rst_sdwr", sdwr_bytes, 0);
        check("rst_rd_data", rd_data, 0);

        // Init gating: commands and pushes are ignored until init_done.
        rst = 1'b0; cmd_valid = 1'b1; cmd_wr = 1'b0; wbuf_push = 1'b1; wbuf_data = 8'hEE;
        bad = 0;
        repeat (100) begin
            nedge();
            if (cmd_ready || sdram_wr_req || sdram_rd_req || busy) bad++;
        end
        check("init_gate", bad, 0);
        cmd_valid = 1'b0; wbuf_push = 1'b0; sdram_init_done = 1'b1;
        nedge();
        check("init_ready", cmd_ready, 1);
        check("init_no_push", wbuf_full, 0);

        push_bytes(BL, 1'b1, 8'h10);
        run_write(2, 1);
        run_read(1, 1'b1);

        // Seven bytes: a write command must not be accepted.
        push_bytes(BL - 1, 1'b0, 8'h00);
        nedge();
        cmd_valid = 1'b1; cmd_wr = 1'b1;
        #1 check("wr7_not_ready", cmd_ready, 0);
        nedge();
        cmd_valid = 1'b0;
        check("wr7_no_req", sdram_wr_req, 0);
        check("wr7_not_busy", busy, 0);
        push_bytes(1, 1'b0, 8'h00);
        check("wr8_full", wbuf_full, 1);
        run_write(0, 0);

        repeat (8) begin
            if ($urandom_range(1) != 0) begin
                push_bytes(BL + int'($urandom_range(3)), 1'b0, 8'h00);
                run_write(int'($urandom_range(4)), int'($urandom_range(4)));
            end else begin
                run_read(int'($urandom_range(4)), 1'b0);
            end
        end

        // Timeout: a full buffer is discarded by the abort.
        push_bytes(BL, 1'b0, 8'h00);
        check("to_full_before", wbuf_full, 1);
        nedge();
        cmd_valid = 1'b1; cmd_wr = 1'b0;
        nedge();
        cmd_valid = 1'b0;
        hi = 0;
        while (sdram_rd_req && hi < 2000) begin
            hi++;
            nedge();
        end
        check("to_req_cycles", hi, TO);
        check("to_err_not_yet", err, 0);
        nedge();
        wq.delete();
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_no_done", done, 0);
        check("to_buf_cleared", wbuf_full, (wq.size() == BL) ? 1 : 0);
        nedge();
        check("to_err_one_cycle", err, 0);

        // Reset in the middle of a write data phase.
        push_bytes(BL, 1'b0, 8'h00);
        nedge();
        cmd_valid = 1'b1; cmd_wr = 1'b1;
        nedge();
        cmd_valid = 1'b0;
        sd_wr_data_en = 1'b1;
        repeat (3) nedge();
        sd_wr_data_en = 1'b0; rst = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b0;
        nedge();
        wq.delete();
        check("mid_rst_outputs", {sdram_wr_req, sdram_rd_req, wbuf_full, cmd_ready,
                                  rd_valid, done, err, busy}, 0);
        check("mid_rst_sdwr", sdwr_bytes, 0);
        rst = 1'b0; cmd_valid = 1'b0;
        nedge();
        check("mid_rst_ready", cmd_ready, 1);
        run_read(0, 1'b0);

        check("req_exclusive", both_hi, 0);
        check("rd_valid_stray", stray, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
